// File: rtl/mux_reply_arbiter.sv
// Packet-atomic round-robin arbiter for the host reply byte streams.
// Each source buffers bytes plus packet lengths; whole packets are issued onto si_dout one at a time.
module mux_reply_arbiter #(
    parameter int unsigned N_SRC   = 6,
    parameter int unsigned FIFO_AW = 11,
    parameter int unsigned LEN_AW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*N_SRC-1:0]   src_din,
    input  logic [N_SRC-1:0]     src_din_en,
    output logic [7:0]           si_dout,
    output logic                 si_dout_en,
    output logic [N_SRC-1:0]     drop_pulse,
    output logic                 busy
);
    localparam int unsigned DEPTH  = 1 << FIFO_AW;
    localparam int unsigned LDEPTH = 1 << LEN_AW;
    localparam int unsigned PW     = FIFO_AW + 1;
    localparam int unsigned LW     = LEN_AW + 1;
    localparam int unsigned SW     = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef logic [PW-1:0] ptr_t;
    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    logic [7:0]      mem  [N_SRC][DEPTH];
    ptr_t            lmem [N_SRC][LDEPTH];
    ptr_t            wr_ptr     [N_SRC];
    ptr_t            commit_ptr [N_SRC];
    ptr_t            rd_ptr     [N_SRC];
    ptr_t            pkt_len    [N_SRC];
    logic [LW-1:0]   lwp [N_SRC];
    logic [LW-1:0]   lrp [N_SRC];
    logic [N_SRC-1:0] synced, in_pkt, dropped;
    logic [N_SRC-1:0] byte_we, len_push, drop_set, drop_end, nonempty;

    state_t          state, state_nx;
    logic [SW-1:0]   last_grant, grant_nx, scan_idx;
    ptr_t            cnt, cnt_nx, len_head;
    logic            pop, rd_en, found, busy_nx;

    // Per-source write-side decisions: accept byte, mark overflow, close packet.
    always_comb begin
        byte_we  = '0;
        len_push = '0;
        drop_set = '0;
        drop_end = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (src_din_en[i] && synced[i] && !dropped[i]) begin
                if ((wr_ptr[i] - rd_ptr[i]) == PW'(DEPTH) || (lwp[i] - lrp[i]) == LW'(LDEPTH))
                    drop_set[i] = 1'b1;
                else
                    byte_we[i] = 1'b1;
            end
            if (!src_din_en[i] && in_pkt[i]) begin
                if (dropped[i]) drop_end[i] = 1'b1;
                else            len_push[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            synced     <= '0;
            in_pkt     <= '0;
            dropped    <= '0;
            drop_pulse <= '0;
            for (int unsigned i = 0; i < N_SRC; i++) begin
                wr_ptr[i]     <= '0;
                commit_ptr[i] <= '0;
                pkt_len[i]    <= '0;
                lwp[i]        <= '0;
            end
        end else begin
            drop_pulse <= drop_end;
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (!src_din_en[i]) synced[i] <= 1'b1;
                in_pkt[i] <= src_din_en[i] & synced[i];
                if (byte_we[i]) begin
                    wr_ptr[i]  <= wr_ptr[i] + PW'(1);
                    pkt_len[i] <= pkt_len[i] + PW'(1);
                end
                if (drop_set[i]) dropped[i] <= 1'b1;
                if (len_push[i]) begin
                    lwp[i]        <= lwp[i] + LW'(1);
                    commit_ptr[i] <= wr_ptr[i];
                    pkt_len[i]    <= '0;
                end
                // Overflowed packet: discard everything written since the last commit.
                if (drop_end[i]) begin
                    wr_ptr[i]  <= commit_ptr[i];
                    dropped[i] <= 1'b0;
                    pkt_len[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (byte_we[i])  mem[i][wr_ptr[i][FIFO_AW-1:0]] <= src_din[8*i +: 8];
            if (len_push[i]) lmem[i][lwp[i][LEN_AW-1:0]]    <= pkt_len[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_SRC; i++) nonempty[i] = (lwp[i] != lrp[i]);
    end

    assign len_head = lmem[last_grant][lrp[last_grant][LEN_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant_nx = last_grant;
        cnt_nx   = cnt;
        pop      = 1'b0;
        rd_en    = 1'b0;
        found    = 1'b0;
        scan_idx = '0;
        case (state)
            IDLE: begin
                for (int unsigned k = 1; k <= N_SRC; k++) begin
                    scan_idx = SW'((32'(last_grant) + k) % N_SRC);
                    if (!found && nonempty[scan_idx]) begin
                        found    = 1'b1;
                        grant_nx = scan_idx;
                    end
                end
                if (found) state_nx = LOAD;
            end
            LOAD: begin
                pop      = 1'b1;
                rd_en    = 1'b1;
                cnt_nx   = len_head - PW'(1);
                state_nx = (len_head == PW'(1)) ? GAP : SEND;
            end
            SEND: begin
                rd_en    = 1'b1;
                cnt_nx   = cnt - PW'(1);
                state_nx = (cnt == PW'(1)) ? GAP : SEND;
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // busy reflects the state and FIFO occupancy that will hold after this edge.
    always_comb begin
        busy_nx = (state_nx != IDLE);
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if ((lwp[i] + LW'(len_push[i])) != (lrp[i] + LW'(pop && (32'(last_grant) == i))))
                busy_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SW'(N_SRC - 1);
            cnt        <= '0;
            si_dout    <= '0;
            si_dout_en <= 1'b0;
            busy       <= 1'b0;
            for (int unsigned i = 0; i < N_SRC; i++) begin
                rd_ptr[i] <= '0;
                lrp[i]    <= '0;
            end
        end else begin
            last_grant <= grant_nx;
            cnt        <= cnt_nx;
            si_dout_en <= rd_en;
            busy       <= busy_nx;
            if (rd_en) begin
                si_dout            <= mem[last_grant][rd_ptr[last_grant][FIFO_AW-1:0]];
                rd_ptr[last_grant] <= rd_ptr[last_grant] + PW'(1);
            end
            if (pop) lrp[last_grant] <= lrp[last_grant] + LW'(1);
        end
    end
endmodule

// File: tb/tb_mux_reply_arbiter.sv
// Directed bench for mux_reply_arbiter: expected bytes and packet lengths are queued when
// stimulus is planned and consumed as the DUT emits them.
module tb_mux_reply_arbiter;
    localparam int unsigned N_SRC = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [8*N_SRC-1:0]   src_din;
    logic [N_SRC-1:0]     src_din_en;
    logic [7:0]           si_dout;
    logic                 si_dout_en;
    logic [N_SRC-1:0]     drop_pulse;
    logic                 busy;

    always #5 clk = ~clk;

    mux_reply_arbiter #(.N_SRC(N_SRC), .FIFO_AW(11), .LEN_AW(3)) dut (
        .clk(clk), .rst(rst), .src_din(src_din), .src_din_en(src_din_en),
        .si_dout(si_dout), .si_dout_en(si_dout_en), .drop_pulse(drop_pulse), .busy(busy)
    );

    int           checks = 0;
    int           failures = 0;
    logic [7:0]   exp_q[$];
    int unsigned  len_q[$];
    int unsigned  run = 0;
    int unsigned  pend_len [N_SRC];
    logic [7:0]   pend_val [N_SRC];
    int unsigned  drop_cnt [N_SRC];
    int unsigned  d_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every valid byte and every completed packet is matched against the queues.
    task automatic sample();
        logic [7:0] e;
        if (si_dout_en === 1'b1) begin
            chk("byte_pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("si_dout", 32'(si_dout), 32'(e));
            end
            run++;
        end else if (run > 0) begin
            chk("pkt_pending", 32'(len_q.size() > 0), 1);
            if (len_q.size() > 0) chk("pkt_len", run, len_q.pop_front());
            run = 0;
        end
        for (int i = 0; i < N_SRC; i++)
            if (drop_pulse[i] === 1'b1) drop_cnt[i]++;
    endtask

    task automatic go(input int unsigned n);
        repeat (n) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (pend_len[i] > 0) begin
                    src_din_en[i]     = 1'b1;
                    src_din[8*i +: 8] = pend_val[i];
                    pend_val[i]       = pend_val[i] + 8'd1;
                    pend_len[i]       = pend_len[i] - 1;
                end else begin
                    src_din_en[i] = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            sample();
        end
    endtask

    task automatic start(input int src, input int unsigned len, input logic [7:0] first);
        pend_len[src] = len;
        pend_val[src] = first;
    endtask

    task automatic push_pkt(input int unsigned len, input logic [7:0] first);
        for (int unsigned j = 0; j < len; j++) exp_q.push_back(first + 8'(j));
        len_q.push_back(len);
    endtask

    task automatic drain(input int unsigned max_cyc);
        int unsigned n = 0;
        while (!(exp_q.size() == 0 && run == 0 && si_dout_en === 1'b0 && busy === 1'b0) && n < max_cyc) begin
            go(1);
            n++;
        end
        chk("drain_in_time", 32'(n < max_cyc), 1);
        chk("pkts_left", len_q.size(), 0);
    endtask

    task automatic do_reset();
        exp_q.delete();
        len_q.delete();
        run = 0;
        rst = 1'b1;
        go(2);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        src_din    = '0;
        src_din_en = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pend_len[i] = 0;
            pend_val[i] = 8'h00;
            drop_cnt[i] = 0;
        end
        go(3);
        rst = 1'b0;
        chk("rst_dout", 32'(si_dout), 0);
        chk("rst_dout_en", 32'(si_dout_en), 0);
        chk("rst_drop", 32'(drop_pulse), 0);
        chk("rst_busy", 32'(busy), 0);
        go(2);

        // Single 10-byte packet: first byte valid three cycles after the end-of-packet cycle.
        start(0, 10, 8'h01);
        push_pkt(10, 8'h01);
        go(10);
        go(1);
        chk("lat_e1_en", 32'(si_dout_en), 0);
        chk("lat_e1_busy", 32'(busy), 1);
        go(1);
        chk("lat_e2_en", 32'(si_dout_en), 0);
        go(1);
        chk("lat_e3_en", 32'(si_dout_en), 1);
        chk("lat_e3_dout", 32'(si_dout), 32'h01);
        drain(100);

        // Two packets ending together after reset: RR from last_grant=5 picks src1 first.
        do_reset();
        go(2);
        chk("rst2_busy", 32'(busy), 0);
        start(3, 6, 8'hB0);
        go(2);
        start(1, 4, 8'hA0);
        push_pkt(4, 8'hA0);
        push_pkt(6, 8'hB0);
        go(4);
        drain(100);

        // src0 back-to-back packets; src2 must follow the first src0 packet.
        push_pkt(8, 8'h10);
        push_pkt(3, 8'hC0);
        push_pkt(8, 8'h20);
        push_pkt(8, 8'h30);
        start(0, 8, 8'h10);
        go(6);
        start(2, 3, 8'hC0);
        go(3);
        start(0, 8, 8'h20);
        go(9);
        start(0, 8, 8'h30);
        go(9);
        drain(200);

        // Exactly full byte FIFO is accepted; one byte beyond it drops the packet.
        start(0, 2048, 8'h00);
        push_pkt(2048, 8'h00);
        go(2048);
        drain(5000);
        d_base = drop_cnt[0];
        start(0, 2050, 8'h00);
        go(2051);
        drain(100);
        chk("ovf_drop_cnt", drop_cnt[0] - d_base, 1);
        start(0, 5, 8'h50);
        push_pkt(5, 8'h50);
        go(5);
        drain(100);

        // Length FIFO overflow: 8 short packets queue behind a long one, the 9th drops.
        d_base = drop_cnt[1];
        start(0, 200, 8'h00);
        push_pkt(200, 8'h00);
        for (int k = 0; k < 8; k++) push_pkt(2, 8'h80 + 8'(2 * k));
        go(205);
        for (int k = 0; k < 9; k++) begin
            start(1, 2, 8'h80 + 8'(2 * k));
            go(3);
        end
        chk("len_drop_cnt", drop_cnt[1] - d_base, 1);
        drain(1000);

        // Reset mid-SEND while src2 is mid-packet: output stops, remainder ignored silently.
        do_reset();
        go(2);
        d_base = drop_cnt[2];
        start(0, 20, 8'h70);
        push_pkt(20, 8'h70);
        go(20);
        go(4);
        start(2, 10, 8'h90);
        go(4);
        chk("mid_send_en", 32'(si_dout_en), 1);
        exp_q.delete();
        len_q.delete();
        run = 0;
        rst = 1'b1;
        go(1);
        chk("rst3_en", 32'(si_dout_en), 0);
        chk("rst3_dout", 32'(si_dout), 0);
        chk("rst3_busy", 32'(busy), 0);
        rst = 1'b0;
        go(8);
        chk("rst3_no_drop", drop_cnt[2] - d_base, 0);
        chk("rst3_idle", 32'(busy), 0);
        start(2, 4, 8'hE0);
        push_pkt(4, 8'hE0);
        go(4);
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
